vga_fb_arbiter: RTL and testbench

//  Shares one single-port 3-bit framebuffer RAM (160x120, each cell shown as a 4x4 pixel block) between two users.
//  - Display scan-out has absolute priority; the block emits rgb_out aligned to the 640x480 VGA timing counters.
//  - A drawing writer uses a valid/ready port and gets every cycle the display does not need.
//  - An optional frame-clear engine sweeps the whole buffer to one colour.
//  - Sits between the VGA timing generator (hcount/vcount source) and the framebuffer RAM.

---
 rtl/vga_fb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port 160x120x3 framebuffer between VGA scan-out and a drawing writer.
// Optional frame-clear engine is built when the FB_CLEAR_EN macro is defined.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk25MHz,
  input  logic              rst_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic [2:0]        rgb_out,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [2:0]        wr_data,
  output logic              wr_drop,
  input  logic              clear_req,
  input  logic [2:0]        clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [2:0]        ram_wdata,
  input  logic [2:0]        ram_rdata
);

  logic [9:0]        tgt_line;
  logic [9:0]        tgt_col;
  logic              line_wrap;
  logic              fetch_slot;
  logic              fetch_d;
  logic [2:0]        pix_latch;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;
  logic              wr_xfer;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [2:0]        clr_color_q;

  // Fetch runs two pixels ahead; the slot at H_TOTAL-2 prefetches block 0 of the next line.
  always_comb begin
    line_wrap = (hcount == 10'(H_TOTAL - 2));
    tgt_line  = vcount;
    tgt_col   = hcount + 10'd2;
    if (line_wrap) begin
      tgt_line = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
      tgt_col  = 10'd0;
    end
    fetch_slot = (hcount[1:0] == 2'b10)
               && ((hcount < 10'(H_ACTIVE - 2)) || line_wrap)
               && (tgt_line < 10'(V_ACTIVE));
  end

  assign fetch_addr  = ADDR_W'(tgt_line[9:2]) * ADDR_W'(FB_W) + ADDR_W'(tgt_col[9:2]);
  assign wr_addr     = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  assign wr_ready    = rst_n && !fetch_slot && !clear_busy;
  assign wr_xfer     = wr_valid && wr_ready;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 3'd0;
    if (rst_n) begin
      if (fetch_slot) begin
        ram_addr = fetch_addr;
      end else if (clr_we) begin
        ram_addr  = clr_addr_q;
        ram_we    = 1'b1;
        ram_wdata = clr_color_q;
      end else if (wr_xfer && wr_in_range) begin
        ram_addr  = wr_addr;
        ram_we    = 1'b1;
        ram_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      fetch_d   <= 1'b0;
      pix_latch <= 3'd0;
      rgb_out   <= 3'd0;
      wr_drop   <= 1'b0;
    end else begin
      fetch_d <= fetch_slot;
      if (fetch_d) begin
        pix_latch <= ram_rdata;
      end
      rgb_out <= ((hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE))) ? pix_latch : 3'd0;
      wr_drop <= wr_xfer && !wr_in_range;
    end
  end

`ifdef FB_CLEAR_EN
  // state    | meaning
  // ST_IDLE  | writer owns every non-fetch cycle; clear_req starts a sweep
  // ST_CLEAR | every non-fetch cycle writes clr_color_q to clr_addr_q, writer blocked
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t state;
  state_t state_nxt;
  logic   clr_last;

  assign clr_last = (clr_addr_q == ADDR_W'(FB_W * FB_H - 1));

  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_we && clr_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == ST_CLEAR);
    clr_we     = (state == ST_CLEAR) && !fetch_slot;
  end

  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      clr_addr_q  <= '0;
      clr_color_q <= 3'd0;
      clear_done  <= 1'b0;
    end else begin
      clear_done <= clr_we && clr_last;
      if ((state == ST_IDLE) && clear_req) begin
        clr_addr_q  <= '0;
        clr_color_q <= clear_color;
      end else if (clr_we) begin
        clr_addr_q <= clr_addr_q + ADDR_W'(1);
      end
    end
  end
`else
  logic unused_clear;

  assign unused_clear = ^{clear_req, clear_color};
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
  assign clr_we       = 1'b0;
  assign clr_addr_q   = '0;
  assign clr_color_q  = 3'd0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized self-checking bench for vga_fb_arbiter with a behavioural framebuffer model.
// The clear-engine scenario is compiled in when FB_CLEAR_EN is defined.
module tb_vga_fb_arbiter;
  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int CELLS = FB_W * FB_H;

  logic        clk25MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic [2:0]  rgb_out;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [2:0]  wr_data = '0;
  logic        wr_drop;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_color = '0;
  logic        clear_busy;
  logic        clear_done;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;

  vga_fb_arbiter dut (
    .clk25MHz(clk25MHz), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .rgb_out(rgb_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_drop(wr_drop), .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .clear_done(clear_done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk25MHz = ~clk25MHz;

  logic [2:0] mem [0:32767];
  logic [2:0] shadow [0:CELLS-1];
  logic       preload = 1'b0;

  always @(posedge clk25MHz) begin
    if (preload) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= shadow[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  int h, v, ph, pv;
  bit scan_ok;

  function automatic int m_line(int hh, int vv);
    return (hh == 798) ? (vv + 1) % 525 : vv;
  endfunction

  function automatic bit m_fetch(int hh, int vv);
    return (hh % 4 == 2) && (hh < 638 || hh == 798) && (m_line(hh, vv) < 480);
  endfunction

  function automatic int m_fetch_addr(int hh, int vv);
    int col = (hh == 798) ? 0 : hh + 2;
    return (m_line(hh, vv) / 4) * FB_W + col / 4;
  endfunction

  function automatic logic [2:0] m_pixel(int hh, int vv);
    if (hh < 640 && vv < 480) return shadow[(vv / 4) * FB_W + hh / 4];
    return 3'd0;
  endfunction

  task automatic set_pos(input int nh, input int nv);
    h = nh; v = nv; scan_ok = 0;
    hcount = 10'(h); vcount = 10'(v);
  endtask

  task automatic tick();
    @(posedge clk25MHz); #1;
    ph = h; pv = v;
    if (ph == 799) scan_ok = 1;
    h++;
    if (h == 800) begin h = 0; v = (v + 1) % 525; end
    hcount = 10'(h); vcount = 10'(v);
  endtask

  task automatic test_reset();
    rst_n = 0; wr_valid = 1; wr_x = 8'd3; wr_y = 7'd2; wr_data = 3'd5;
    set_pos(100, 10);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_cmp++;
      if (wr_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 15'd0) begin
        n_err++; $display("FAIL reset_hold: ready=%b we=%b addr=%0d expected 0/0/0", wr_ready, ram_we, ram_addr);
      end
      n_cmp++;
      if (rgb_out !== 3'd0 || wr_drop !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
        n_err++; $display("FAIL reset_regs: rgb=%0d drop=%b busy=%b done=%b expected all 0", rgb_out, wr_drop, clear_busy, clear_done);
      end
    end
    rst_n = 1; set_pos(2, 0); #1;
    n_cmp++;
    if (wr_ready !== 1'b0 || ram_addr !== 15'(m_fetch_addr(2, 0)) || ram_we !== 1'b0) begin
      n_err++; $display("FAIL release_fetch: ready=%b addr=%0d we=%b expected 0/%0d/0", wr_ready, ram_addr, ram_we, m_fetch_addr(2, 0));
    end
    tick(); #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'(2 * FB_W + 3) || ram_wdata !== 3'd5) begin
      n_err++; $display("FAIL release_grant: ready=%b we=%b addr=%0d data=%0d expected 1/1/%0d/5", wr_ready, ram_we, ram_addr, ram_wdata, 2 * FB_W + 3);
    end
    shadow[2 * FB_W + 3] = 3'd5;
    tick(); wr_valid = 0; #1;
    n_cmp++;
    if (wr_drop !== 1'b0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL release_idle: drop=%b we=%b expected 0/0", wr_drop, ram_we);
    end
  endtask

  task automatic test_scan_out();
    shadow[0] = 3'b101; shadow[1] = 3'b010;
    preload = 1; tick(); preload = 0;
    wr_valid = 0;
    set_pos(796, 524);
    for (int i = 0; i < 1604; i++) begin
      tick(); #1;
      n_cmp++;
      if (wr_ready !== !m_fetch(h, v)) begin
        n_err++; $display("FAIL scan_ready h=%0d v=%0d: got %b expected %b", h, v, wr_ready, !m_fetch(h, v));
      end
      if (m_fetch(h, v)) begin
        n_cmp++;
        if (ram_addr !== 15'(m_fetch_addr(h, v)) || ram_we !== 1'b0) begin
          n_err++; $display("FAIL scan_fetch_addr h=%0d v=%0d: got %0d expected %0d", h, v, ram_addr, m_fetch_addr(h, v));
        end
      end
      if (scan_ok || !(ph < 640 && pv < 480)) begin
        n_cmp++;
        if (rgb_out !== m_pixel(ph, pv)) begin
          n_err++; $display("FAIL scan_pixel h=%0d v=%0d: got %0d expected %0d", ph, pv, rgb_out, m_pixel(ph, pv));
        end
      end
      if (pv == 0 && ph < 8) begin
        n_cmp++;
        if (rgb_out !== ((ph < 4) ? 3'b101 : 3'b010)) begin
          n_err++; $display("FAIL scan_corner h=%0d: got %b expected %b", ph, rgb_out, (ph < 4) ? 3'b101 : 3'b010);
        end
      end
    end
  endtask

  task automatic test_fetch_collision();
    int x, y, grants, fetches;
    grants = 0; fetches = 0;
    set_pos(796, 9);
    for (int i = 0; i < 1700; i++) begin
      tick();
      x = $urandom_range(0, FB_W - 1); y = $urandom_range(100, FB_H - 1);
      wr_valid = 1; wr_x = 8'(x); wr_y = 7'(y); wr_data = 3'($urandom);
      #1;
      n_cmp++;
      if (wr_ready !== !m_fetch(h, v)) begin
        n_err++; $display("FAIL collide_ready h=%0d v=%0d: got %b expected %b", h, v, wr_ready, !m_fetch(h, v));
      end
      if (!m_fetch(h, v)) begin
        grants++;
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 15'(y * FB_W + x) || ram_wdata !== wr_data) begin
          n_err++; $display("FAIL collide_write: we=%b addr=%0d data=%0d expected 1/%0d/%0d", ram_we, ram_addr, ram_wdata, y * FB_W + x, wr_data);
        end
        shadow[y * FB_W + x] = wr_data;
      end else begin
        fetches++;
        n_cmp++;
        if (ram_we !== 1'b0 || ram_addr !== 15'(m_fetch_addr(h, v))) begin
          n_err++; $display("FAIL collide_fetch h=%0d v=%0d: we=%b addr=%0d expected 0/%0d", h, v, ram_we, ram_addr, m_fetch_addr(h, v));
        end
      end
      if (scan_ok || !(ph < 640 && pv < 480)) begin
        n_cmp++;
        if (rgb_out !== m_pixel(ph, pv)) begin
          n_err++; $display("FAIL collide_pixel h=%0d v=%0d: got %0d expected %0d", ph, pv, rgb_out, m_pixel(ph, pv));
        end
      end
    end
    wr_valid = 0;
    n_cmp++;
    if (fetches * 4 > 1700 + 8 || grants + fetches != 1700) begin
      n_err++; $display("FAIL collide_share: grants=%0d fetches=%0d expected fetches<=1/4", grants, fetches);
    end
  endtask

  task automatic test_out_of_range();
    int tx [6] = '{160, 159, 255, 0, 5, 159};
    int ty [6] = '{5, 119, 0, 120, 7, 127};
    int x, y;
    bit vld, xfer, inr, exp_drop;
    exp_drop = 0;
    set_pos(100, 490);
    for (int i = 0; i < 160; i++) begin
      tick();
      if (i < 6) begin x = tx[i]; y = ty[i]; vld = 1; end
      else if (i < 150) begin x = $urandom_range(0, 200); y = $urandom_range(0, 127); vld = 1'($urandom); end
      else begin x = 0; y = 0; vld = 0; end
      wr_valid = vld; wr_x = 8'(x); wr_y = 7'(y); wr_data = 3'($urandom);
      #1;
      n_cmp++;
      if (wr_drop !== exp_drop) begin
        n_err++; $display("FAIL oor_drop i=%0d: got %b expected %b", i, wr_drop, exp_drop);
      end
      xfer = vld && !m_fetch(h, v);
      inr = (x < FB_W) && (y < FB_H);
      n_cmp++;
      if (xfer && inr) begin
        if (ram_we !== 1'b1 || ram_addr !== 15'(y * FB_W + x) || ram_wdata !== wr_data) begin
          n_err++; $display("FAIL oor_write x=%0d y=%0d: we=%b addr=%0d expected 1/%0d", x, y, ram_we, ram_addr, y * FB_W + x);
        end
        shadow[y * FB_W + x] = wr_data;
      end else if (ram_we !== 1'b0) begin
        n_err++; $display("FAIL oor_nowrite x=%0d y=%0d: we=%b expected 0", x, y, ram_we);
      end
      exp_drop = xfer && !inr;
    end
    wr_valid = 0;
  endtask

  task automatic test_wrap();
    int x, y;
    wr_valid = 0;
    tick(); set_pos(798, 524); #1;
    n_cmp++;
    if (wr_ready !== 1'b0 || ram_addr !== 15'd0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL wrap_frame: ready=%b addr=%0d we=%b expected 0/0/0", wr_ready, ram_addr, ram_we);
    end
    tick(); set_pos(798, 479); #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL wrap_last_line: ready=%b we=%b expected 1/0", wr_ready, ram_we);
    end
    tick(); set_pos(796, 479);
    for (int i = 0; i < 1800; i++) begin
      tick();
      x = $urandom_range(0, FB_W - 1); y = $urandom_range(0, 1);
      wr_valid = 1'($urandom); wr_x = 8'(x); wr_y = 7'(y); wr_data = 3'($urandom);
      #1;
      n_cmp++;
      if (wr_ready !== 1'b1) begin
        n_err++; $display("FAIL blank_ready h=%0d v=%0d: got %b expected 1", h, v, wr_ready);
      end
      if (wr_valid) shadow[y * FB_W + x] = wr_data;
      n_cmp++;
      if (rgb_out !== 3'd0) begin
        n_err++; $display("FAIL blank_rgb h=%0d v=%0d: got %0d expected 0", ph, pv, rgb_out);
      end
    end
    wr_valid = 0;
    tick(); set_pos(796, 524);
    for (int i = 0; i < 6404; i++) begin
      tick(); #1;
      n_cmp++;
      if (wr_ready !== !m_fetch(h, v)) begin
        n_err++; $display("FAIL wrap_ready h=%0d v=%0d: got %b expected %b", h, v, wr_ready, !m_fetch(h, v));
      end
      if (scan_ok || !(ph < 640 && pv < 480)) begin
        n_cmp++;
        if (rgb_out !== m_pixel(ph, pv)) begin
          n_err++; $display("FAIL wrap_pixel h=%0d v=%0d: got %0d expected %0d", ph, pv, rgb_out, m_pixel(ph, pv));
        end
      end
    end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int starts [3] = '{524, 239, 475};
    int cnt;
    bit exp_busy, exp_done, nb, nd, finished;
    tick(); set_pos(100, 300);
    clear_req = 1; clear_color = 3'b111;
    wr_valid = 1; wr_x = 8'd10; wr_y = 7'd50; wr_data = 3'd3;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'(50 * FB_W + 10) || ram_wdata !== 3'd3 || clear_busy !== 1'b0) begin
      n_err++; $display("FAIL clear_start_writer: ready=%b we=%b addr=%0d busy=%b expected 1/1/%0d/0", wr_ready, ram_we, ram_addr, clear_busy, 50 * FB_W + 10);
    end
    shadow[50 * FB_W + 10] = 3'd3;
    exp_busy = 1; exp_done = 0; cnt = 0; finished = 0;
    for (int k = 0; k < 40000 && !finished; k++) begin
      tick();
      clear_req = (k == 50);
      clear_color = (k == 50) ? 3'd0 : 3'd7;
      wr_valid = exp_busy ? 1'($urandom) : 1'b0;
      wr_x = 8'($urandom_range(0, FB_W - 1)); wr_y = 7'($urandom_range(0, FB_H - 1));
      #1;
      n_cmp++;
      if (clear_busy !== exp_busy) begin
        n_err++; $display("FAIL clear_busy k=%0d: got %b expected %b", k, clear_busy, exp_busy);
      end
      n_cmp++;
      if (clear_done !== exp_done) begin
        n_err++; $display("FAIL clear_done k=%0d: got %b expected %b", k, clear_done, exp_done);
      end
      if (exp_done) finished = 1;
      nb = exp_busy; nd = 0;
      if (exp_busy) begin
        n_cmp++;
        if (wr_ready !== 1'b0) begin
          n_err++; $display("FAIL clear_block k=%0d: ready=%b expected 0", k, wr_ready);
        end
        n_cmp++;
        if (!m_fetch(h, v)) begin
          if (ram_we !== 1'b1 || ram_addr !== 15'(cnt) || ram_wdata !== 3'b111) begin
            n_err++; $display("FAIL clear_write k=%0d: we=%b addr=%0d data=%0d expected 1/%0d/7", k, ram_we, ram_addr, ram_wdata, cnt);
          end
          cnt++;
          if (cnt == CELLS) begin
            nb = 0; nd = 1;
            for (int i = 0; i < CELLS; i++) shadow[i] = 3'b111;
          end
        end else if (ram_we !== 1'b0) begin
          n_err++; $display("FAIL clear_fetch_prio k=%0d: we=%b expected 0", k, ram_we);
        end
      end
      exp_busy = nb; exp_done = nd;
    end
    clear_req = 0; wr_valid = 0;
    n_cmp++;
    if (!finished || cnt != CELLS) begin
      n_err++; $display("FAIL clear_complete: writes=%0d done_seen=%b expected %0d/1", cnt, finished, CELLS);
    end
    tick(); #1;
    n_cmp++;
    if (clear_done !== 1'b0 || clear_busy !== 1'b0) begin
      n_err++; $display("FAIL clear_pulse_once: done=%b busy=%b expected 0/0", clear_done, clear_busy);
    end
    for (int s = 0; s < 3; s++) begin
      set_pos(796, starts[s]);
      for (int i = 0; i < 1604; i++) begin
        tick(); #1;
        if (scan_ok || !(ph < 640 && pv < 480)) begin
          n_cmp++;
          if (rgb_out !== m_pixel(ph, pv)) begin
            n_err++; $display("FAIL clear_pixel h=%0d v=%0d: got %0d expected %0d", ph, pv, rgb_out, m_pixel(ph, pv));
          end
        end
      end
    end
  endtask
`else
  task automatic test_clear();
    tick(); set_pos(200, 100);
    for (int k = 0; k < 40; k++) begin
      tick();
      clear_req = 1; clear_color = 3'($urandom); wr_valid = 0;
      #1;
      n_cmp++;
      if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
        n_err++; $display("FAIL noclear_flags k=%0d: busy=%b done=%b expected 0/0", k, clear_busy, clear_done);
      end
      n_cmp++;
      if (wr_ready !== !m_fetch(h, v)) begin
        n_err++; $display("FAIL noclear_ready h=%0d: got %b expected %b", h, wr_ready, !m_fetch(h, v));
      end
    end
    clear_req = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < CELLS; i++) shadow[i] = 3'($urandom);
    set_pos(0, 0);
    preload = 1; tick(); preload = 0;
    test_reset();
    test_scan_out();
    test_fetch_collision();
    test_out_of_range();
    test_wrap();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
